md_sched: RTL and testbench

- Multiply/divide scheduler for the 5-stage pipeline. It owns the HI/LO registers, sequences multi-cycle MULT/MULTU/DIV/DIVU operations issued from EX, and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request to the ID-stage hazard logic while an ID-stage HI/LO-class instruction would collide with a running or starting operation.
- Sits beside the ALU in EX; its read data joins the EX result mux.

---
 rtl/md_sched.sv | 189 ++++++++++++++++++
 tb/tb_md_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched -- multiply/divide scheduler for the EX stage.
//
// Owns the HI/LO registers. MULT/MULTU/DIV/DIVU run for a fixed number of
// cycles; the result is computed when the operation starts, held in a pending
// register, and committed to HI/LO in the cycle busy falls. MTHI/MTLO write
// HI/LO directly while idle, and MFHI/MFLO are served combinationally.
//
// Optional feature: define MD_SCHED_MADD_EN to accept MADD (op 9) and
// MADDU (op 10), which accumulate a product into {HI,LO}. Without it those
// opcodes behave as NONE.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (and MADD/MADDU), 1..15
//   DIV_CYCLES   busy cycles for DIV/DIVU, 1..15
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous active-low reset
//   ex_md_op     EX-stage multiply/divide opcode
//   ex_rs/ex_rt  forwarded operands in EX
//   id_md_op     ID-stage opcode, used only for the stall request
//   busy         an operation is in flight (registered)
//   md_stall     stall request to ID/IF (combinational)
//   hi/lo        HI and LO registers
//   ex_md_rdata  MFHI/MFLO read data (combinational)

module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ex_md_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic [3:0]  id_md_op,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] ex_md_rdata
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } md_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic [31:0] pend_hi_d, pend_lo_d;

  logic        ex_is_mul, ex_is_div, start, id_class;

  // Operation decode
  always_comb begin
    ex_is_mul = 1'b0;
    ex_is_div = 1'b0;
    case (ex_md_op)
      OP_MULT, OP_MULTU: ex_is_mul = 1'b1;
      OP_DIV,  OP_DIVU:  ex_is_div = 1'b1;
`ifdef MD_SCHED_MADD_EN
      OP_MADD, OP_MADDU: ex_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    id_class = 1'b0;
    case (id_md_op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: id_class = 1'b1;
`ifdef MD_SCHED_MADD_EN
      OP_MADD, OP_MADDU: id_class = 1'b1;
`endif
      default: ;
    endcase
  end

  assign start = (ex_is_mul || ex_is_div) && (state_q == S_IDLE);

  // Arithmetic datapath
  logic [63:0] prod_s, prod_u;
  logic        div_signed, div_by_zero;
  logic [31:0] mag_a, mag_b, uq, ur, quot, rem;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod_s = {{32{ex_rs[31]}}, ex_rs} * {{32{ex_rt[31]}}, ex_rt};
    prod_u = {32'd0, ex_rs} * {32'd0, ex_rt};

    // Signed division on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend's sign. Avoids the -2^31 / -1 overflow case.
    div_signed  = (ex_md_op == OP_DIV);
    div_by_zero = (ex_rt == '0);
    mag_a = (div_signed && ex_rs[31]) ? (~ex_rs + 32'd1) : ex_rs;
    mag_b = (div_signed && ex_rt[31]) ? (~ex_rt + 32'd1) : ex_rt;
    if (div_by_zero) mag_b = 32'd1;
    uq   = mag_a / mag_b;
    ur   = mag_a % mag_b;
    quot = (div_signed && (ex_rs[31] ^ ex_rt[31])) ? (~uq + 32'd1) : uq;
    rem  = (div_signed && ex_rs[31]) ? (~ur + 32'd1) : ur;

    {pend_hi_d, pend_lo_d} = {hi_q, lo_q};
    case (ex_md_op)
      OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
      OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (!div_by_zero) {pend_hi_d, pend_lo_d} = {rem, quot};
      end
`ifdef MD_SCHED_MADD_EN
      OP_MADD:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
      OP_MADDU: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
`endif
      default: ;
    endcase
  end

  // Control FSM with HI/LO and busy registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= ex_is_div ? DIV_N : MULT_N;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
          end else if (ex_md_op == OP_MTHI) begin
            hi_q <= ex_rs;
          end else if (ex_md_op == OP_MTLO) begin
            lo_q <= ex_rs;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = id_class && (busy_q || start);

  always_comb begin
    ex_md_rdata = '0;
    if (ex_md_op == OP_MFHI)      ex_md_rdata = hi_q;
    else if (ex_md_op == OP_MFLO) ex_md_rdata = lo_q;
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases followed by random traffic,
// all checked against a cycle-count reference model of HI/LO behaviour.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MD_SCHED_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ex_md_op, id_md_op;
  logic [31:0] ex_rs, ex_rt;
  logic        busy, md_stall;
  logic [31:0] hi, lo, ex_md_rdata;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .ex_md_op(ex_md_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_md_op(id_md_op), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo),
    .ex_md_rdata(ex_md_rdata)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural HI/LO, result waiting to land, cycles left.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;

  function automatic bit f_start_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (MADD && (op == 4'd9 || op == 4'd10));
  endfunction

  function automatic bit f_class(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd8) || (MADD && (op == 4'd9 || op == 4'd10));
  endfunction

  function automatic longint f_abs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_result(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    logic [63:0] p;
    rh = m_hi;
    rl = m_lo;
    sa = longint'(int'(rs));
    sb = longint'(int'(rt));
    case (op)
      4'd1: begin p = sa * sb; {rh, rl} = p; end
      4'd2: begin p = {32'd0, rs} * {32'd0, rt}; {rh, rl} = p; end
      4'd3: if (rt != 0) begin
        q = f_abs(sa) / f_abs(sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        rl = 32'(q);
        rh = 32'(r);
      end
      4'd4: if (rt != 0) begin rl = rs / rt; rh = rs % rt; end
      4'd9:  begin p = {m_hi, m_lo} + 64'(sa * sb); {rh, rl} = p; end
      4'd10: begin p = {m_hi, m_lo} + {32'd0, rs} * {32'd0, rt}; {rh, rl} = p; end
      default: ;
    endcase
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model
  // at posedge, then check registered outputs.
  task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [3:0] idop);
    bit st;
    @(negedge clk);
    ex_md_op = op; ex_rs = rs; ex_rt = rt; id_md_op = idop;
    #1;
    st = (m_left == 0) && f_start_op(op);
    chk("md_stall", {31'd0, md_stall}, {31'd0, f_class(idop) && (m_left > 0 || st)});
    chk("ex_md_rdata", ex_md_rdata, (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0);
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (st) begin
      m_result(op, rs, rt, m_phi, m_plo);
      m_left = (op == 4'd3 || op == 4'd4) ? DC : MC;
    end else if (op == 4'd7) begin
      m_hi = rs;
    end else if (op == 4'd8) begin
      m_lo = rs;
    end
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n, input logic [3:0] idop);
    for (int i = 0; i < n; i++) cyc(4'd0, 32'd0, 32'd0, idop);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0; ex_md_op = 4'd0; id_md_op = 4'd0;
    #1;
    m_hi = '0; m_lo = '0; m_left = 0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] f_operand();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 15));
      2: return -32'($urandom_range(1, 15));
      3: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; ex_md_op = '0; id_md_op = '0; ex_rs = '0; ex_rt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_hi", hi, 32'd0);
    chk("init_lo", lo, 32'd0);
    chk("init_stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT / MULTU of -1 * 2
    cyc(4'd1, 32'hFFFF_FFFF, 32'd2, 4'd0); idle(MC, 4'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFE);
    cyc(4'd2, 32'hFFFF_FFFF, 32'd2, 4'd0); idle(MC, 4'd0);
    chk("multu_hi", hi, 32'h0000_0001); chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2, then DIVU by zero keeps HI/LO
    cyc(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0); idle(DC, 4'd0);
    chk("div_hi", hi, 32'hFFFF_FFFF); chk("div_lo", lo, 32'hFFFF_FFFD);
    cyc(4'd7, 32'h11, 32'd0, 4'd0); cyc(4'd8, 32'h22, 32'd0, 4'd0);
    cyc(4'd4, 32'd7, 32'd0, 4'd0); idle(DC, 4'd0);
    chk("div0_hi", hi, 32'h11); chk("div0_lo", lo, 32'h22);

    // Stall while MFLO waits in ID, then MFLO reads the new LO
    cyc(4'd1, 32'd3, 32'd4, 4'd6); idle(MC, 4'd6); idle(1, 4'd6);
    cyc(4'd6, 32'd0, 32'd0, 4'd0);
    chk("mflo_new", ex_md_rdata, 32'd12);

    // MTHI / MFHI / NONE
    cyc(4'd7, 32'hDEAD_BEEF, 32'd0, 4'd0);
    chk("mthi", hi, 32'hDEAD_BEEF);
    cyc(4'd5, 32'd0, 32'd0, 4'd0);
    cyc(4'd0, 32'd0, 32'd0, 4'd0);

    // Reset during DIV, then MULT 3*4
    cyc(4'd3, 32'd100, 32'd7, 4'd0); idle(2, 4'd0);
    pulse_reset();
    cyc(4'd1, 32'd3, 32'd4, 4'd0); idle(MC, 4'd0);
    chk("post_rst_lo", lo, 32'd12);

    // MADD 3*4 onto {0,5}
    cyc(4'd7, 32'd0, 32'd0, 4'd0); cyc(4'd8, 32'd5, 32'd0, 4'd0);
    cyc(4'd9, 32'd3, 32'd4, 4'd9); idle(MC, 4'd0);
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, MADD ? 32'd17 : 32'd5);

    // Random traffic, including ops issued while busy and occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else cyc(4'($urandom_range(0, 15)), f_operand(), f_operand(), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
